data_memory_lsu: RTL and testbench
==================================

# data_memory_lsu

Parametrised byte-addressable data memory with an integrated load/store formatting stage, for the RISC-V core's memory stage. It supports all RV32I load and store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) and uses little-endian byte lanes. Reads are registered, with a request/response handshake. After reset, the memory clears itself one word per cycle, so no full-array reset fan-out is needed. Misaligned, out-of-range or illegal accesses are rejected with a fault pulse instead of corrupting memory.

## Interface
- DEPTH_WORDS, 64, number of 32-bit words; power of two, ≥ 2
- ADDR_W, 32, width of the byte address input
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, qualified by ready
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I access size/sign code
- addr  in  ADDR_W  byte address
- wdata  in  32  store data; the low bytes are used for SB/SH
- ready  out  1  block can accept a request this cycle
- rvalid  out  1  one-cycle pulse; rdata valid (loads only)
- rdata  out  32  load result, sign/zero-extended
- fault  out  1  one-cycle pulse; the accepted request was rejected

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0]. Byte k of a word holds address 4·index+k.
- Accept condition: req && ready. When req is low or ready is low, inputs are ignored.
- States:
  - CLEAR: counter clr_idx writes 0 to word clr_idx and increments each cycle. ready = 0. Leave for RUN after writing word DEPTH_WORDS-1.
  - RUN: ready = 1 every cycle, so the block sustains one access per cycle.
- Reset forces CLEAR with clr_idx = 0 from any state, including mid-clear, which restarts from 0. A request accepted in the same cycle as reset is discarded.
- Fault conditions, checked at accept:
  - funct3 ∈ {011, 110, 111} (any access)
  - store with funct3[2] = 1
  - halfword access with addr[0] ≠ 0
  - word access with addr[1:0] ≠ 0
  - any addr bit above log2(DEPTH_WORDS)+1 set (out of range)
- A faulting access writes nothing. It gives fault = 1 and rvalid = 0 next cycle, and rdata = 0.
- Stores (funct3 000/001/010) write only the addressed lane(s) at the accept edge. Other bytes are unchanged.
  - SB: wdata[7:0] goes to lane addr[1:0].
  - SH: wdata[15:0] goes to lanes addr[1] ×2 and +1.
  - SW: all four lanes.
- Loads sample the array at the accept edge. The selected lane(s) are extended:
  - 000 LB: sign-extend
  - 100 LBU: zero-extend
  - 001 LH: sign-extend
  - 101 LHU: zero-extend
  - 010 LW: full word
- Stores produce no rvalid. A successful store produces neither fault nor rvalid.

## Timing
- Reset values: ready = 0, rvalid = 0, fault = 0, rdata = 0, state = CLEAR, clr_idx = 0.
- The clear takes DEPTH_WORDS cycles. Counting the first cycle with reset low as cycle 0, ready is 1 in cycle DEPTH_WORDS.
- Load latency is 1. If a load is accepted at edge n, rvalid/rdata are valid in the cycle after edge n, for one cycle only. rdata returns to 0 when rvalid is low.
- A store accepted at edge n is visible to a load accepted at edge n+1. There is no same-cycle bypass, since only one access is accepted per cycle.
- Back-to-back loads produce back-to-back rvalid pulses.
- fault has the same 1-cycle latency as rvalid. The two are never high together.
- Reset asserted while a response is pending suppresses that response. All outputs read 0 the cycle after the reset edge.

## Test plan
- Reset, hold for 2 cycles, release. Expected: ready stays 0 for exactly 64 cycles then rises; a LW from every word returns 0x00000000.
- SW 0x8081_F27F to addr 0x10, then load addr 0x10 in every size. Expected:
  - LW = 0x8081F27F
  - LB@0x10 = 0x0000007F; LB@0x11 = 0xFFFFFFF2; LBU@0x11 = 0x000000F2
  - LH@0x12 = 0xFFFF8081; LHU@0x12 = 0x00008081
- SW 0x11223344 @0x20, then SB 0xAA @0x22, then SH 0xBEEF @0x20. Expected: LW @0x20 = 0x11AABEEF.
- Each of the following gives a fault pulse 1 cycle later, no rvalid, and memory unchanged (checked by LW):
  - LH @0x21
  - LW @0x22
  - SW @0x100 (out of range for DEPTH_WORDS = 64)
  - load with funct3 = 011
  - store with funct3 = 100
- Alternate SW @0x0 value i and LW @0x0 every cycle for 20 cycles. Expected: each LW returns the value of the preceding SW; rvalid pulses on the cycles following the loads.
- Assert reset at clear cycle 30 and again while a LW response is pending. Expected: clear restarts (ready low for a further 64 cycles); the pending rvalid is never seen.

Source files
------------

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable data memory with RV32I load/store formatting and self-clear after reset
// Ports: clk/reset (sync, active-high); req/we/funct3/addr/wdata request an access when ready;
// rvalid/rdata return a formatted load one cycle after accept; fault pulses one cycle after a rejected access.
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              fault
);
    localparam int IW = $clog2(DEPTH_WORDS);
    typedef enum logic {CLEAR, RUN} state_e;
    state_e        state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          rvalid_q, rvalid_d, fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          bad, accept, st_ok;
    logic [3:0]    be;
    logic [31:0]   wd, word, ld;
    logic [7:0]    b;
    logic [15:0]   h;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = (state_q == CLEAR && clr_idx_q == IW'(DEPTH_WORDS - 1)) ? RUN : state_q;
        clr_idx_d = (state_q == CLEAR) ? clr_idx_q + IW'(1) : clr_idx_q;
    end

    always_comb begin
        ready = (state_q == RUN);
    end

    assign idx  = addr[IW+1:2];
    assign lane = addr[1:0];
    // Any bit above the word index set means the address lies outside the array.
    assign bad  = funct3[1:0] == 2'b11 || funct3 == 3'b110 || (we && funct3[2])
                || (funct3[1:0] == 2'b01 && addr[0])
                || (funct3[1:0] == 2'b10 && |addr[1:0])
                || |(addr >> (IW + 2));
    // A request coinciding with reset is dropped, even if the block was in RUN.
    assign accept = req && ready && !reset;
    assign st_ok  = accept && we && !bad;

    always_comb begin
        be   = funct3[1:0] == 2'b00 ? 4'b0001 << lane
             : funct3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd   = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}}
             : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        word = mem_q[idx];
        b    = word[{lane, 3'b000} +: 8];
        h    = lane[1] ? word[31:16] : word[15:0];
        ld   = funct3[1:0] == 2'b00 ? {{24{b[7] & ~funct3[2]}}, b}
             : funct3[1:0] == 2'b01 ? {{16{h[15] & ~funct3[2]}}, h} : word;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR)
                mem_q[clr_idx_q] <= '0;
            else if (st_ok)
                for (int k = 0; k < 4; k++)
                    if (be[k]) mem_q[idx][8*k +: 8] <= wd[8*k +: 8];
        end
    end

    always_comb begin
        rvalid_d = accept && !we && !bad;
        fault_d  = accept && bad;
        rdata_d  = rvalid_d ? ld : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign fault  = fault_q;
    assign rdata  = rdata_q;
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: randomized and directed checks of data_memory_lsu against a byte-array model
module tb_data_memory_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, rvalid, fault;
    logic [31:0] rdata;
    int          n_vec = 0;
    int          n_bad = 0;
    bit   [7:0]  mem_m [256];

    data_memory_lsu #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        foreach (mem_m[i]) mem_m[i] = 8'h00;
    endtask

    function automatic void model(input bit w, input bit [2:0] f, input bit [31:0] a, input bit [31:0] d,
                                  output bit erv, output bit efl, output bit [31:0] erd);
        int unsigned sz = (f[1:0] == 0) ? 1 : (f[1:0] == 1) ? 2 : 4;
        int unsigned v = 0;
        erv = 0; efl = 0; erd = 0;
        if (f[1:0] == 3 || f == 6 || (w && f[2]) || a >= 256 || a % sz != 0) begin
            efl = 1;
        end else if (w) begin
            for (int i = 0; i < int'(sz); i++) mem_m[a + i] = 8'((d >> (8 * i)) & 32'hFF);
        end else begin
            for (int i = 0; i < int'(sz); i++) v = v | (int'(mem_m[a + i]) << (8 * i));
            if (!f[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            erv = 1;
            erd = v;
        end
    endfunction

    task automatic access(input bit w, input bit [2:0] f, input bit [31:0] a, input bit [31:0] d);
        bit erv, efl;
        bit [31:0] erd;
        req = 1; we = w; funct3 = f; addr = a; wdata = d;
        model(w, f, a, d, erv, efl, erd);
        @(posedge clk); #1;
        req = 0;
        chk("rvalid", {31'b0, rvalid}, {31'b0, erv});
        chk("fault", {31'b0, fault}, {31'b0, efl});
        chk("rdata", rdata, erd);
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (!ready && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(tag, cnt, 64);
        model_clear();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, {31'b0, ready}, 0);
        chk({tag, "_rvalid"}, {31'b0, rvalid}, 0);
        chk({tag, "_fault"}, {31'b0, fault}, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_zero("rst");
        reset = 0;
        wait_ready("clear_len");
        for (int w = 0; w < 64; w++) access(0, 3'b010, w * 4, 0);

        access(1, 3'b010, 32'h10, 32'h8081_F27F);
        access(0, 3'b010, 32'h10, 0); chk("tp_lw", rdata, 32'h8081_F27F);
        access(0, 3'b000, 32'h10, 0); chk("tp_lb10", rdata, 32'h0000_007F);
        access(0, 3'b000, 32'h11, 0); chk("tp_lb11", rdata, 32'hFFFF_FFF2);
        access(0, 3'b100, 32'h11, 0); chk("tp_lbu11", rdata, 32'h0000_00F2);
        access(0, 3'b001, 32'h12, 0); chk("tp_lh12", rdata, 32'hFFFF_8081);
        access(0, 3'b101, 32'h12, 0); chk("tp_lhu12", rdata, 32'h0000_8081);

        access(1, 3'b010, 32'h20, 32'h1122_3344);
        access(1, 3'b000, 32'h22, 32'h0000_00AA);
        access(1, 3'b001, 32'h20, 32'h0000_BEEF);
        access(0, 3'b010, 32'h20, 0); chk("tp_merge", rdata, 32'h11AA_BEEF);

        access(0, 3'b001, 32'h21, 0);        chk("f_lh", {31'b0, fault}, 1);
        access(0, 3'b010, 32'h22, 0);        chk("f_lw", {31'b0, fault}, 1);
        access(1, 3'b010, 32'h100, 32'hDEAD_BEEF); chk("f_oor", {31'b0, fault}, 1);
        access(0, 3'b011, 32'h20, 0);        chk("f_f3", {31'b0, fault}, 1);
        access(1, 3'b100, 32'h20, 32'h5555_5555); chk("f_st", {31'b0, fault}, 1);
        access(0, 3'b010, 32'h20, 0);        chk("f_keep", rdata, 32'h11AA_BEEF);
        access(0, 3'b010, 32'h0, 0);         chk("f_keep0", rdata, 32'h0);

        for (int i = 1; i <= 20; i++) begin
            access(1, 3'b010, 32'h0, i);
            access(0, 3'b010, 32'h0, 0);
        end

        for (int i = 0; i < 400; i++) begin
            bit [31:0] a = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 263);
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
        @(posedge clk); #1;
        chk("idle_rvalid", {31'b0, rvalid}, 0);
        chk("idle_rdata", rdata, 0);

        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_ready", {31'b0, ready}, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk_zero("mid_rst");
        wait_ready("restart_len");
        for (int w = 0; w < 64; w++) access(0, 3'b010, w * 4, 0);

        access(1, 3'b010, 32'h10, 32'hCAFE_F00D);
        req = 1; we = 0; funct3 = 3'b010; addr = 32'h10; reset = 1;
        @(posedge clk); #1;
        req = 0; reset = 0;
        chk_zero("pend");
        wait_ready("pend_len");
        access(0, 3'b010, 32'h10, 0);
        chk("pend_clr", rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
